hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Generates the `stall` input of the ID/EX pipeline register, plus the matching hold signals for PC and IF/ID.
- Detects two hazards:
  - load-use hazards;
  - HI/LO or divider-structural hazards while the multi-cycle divider is running.
- Tracks divider occupancy with a small state machine and down-counter.
- Keeps a saturating stall-cycle performance counter.
- Sits between ID decode and the ID/EX register; clocked on the same negedge as all pipeline registers.

Parameters:
- DIV_CYCLES, 32, number of cycles the divider occupies after a divide enters EX (legal range 2..63).
- CNT_W, 6, width of the divider down-counter; must satisfy 2^CNT_W > DIV_CYCLES.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- cpu_clk  in  1  pipeline clock; all state updates on negedge.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  branch/exception flush of IF/ID this cycle; overrides stall outputs.
- ID_rs  in  5  rs field of instruction in ID.
- ID_rt  in  5  rt field of instruction in ID.
- ID_uses_rt  in  1  ID instruction reads rt as a source.
- ID_DivSel  in  1  ID instruction is div/divu.
- ID_HiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_RegWrite  in  1  instruction in EX writes the register file.
- EX_wr_addr  in  5  destination register of the EX instruction (after RegDst mux).
- EX_DivSel  in  1  instruction in EX is a divide (divider start).
- pc_hold  out  1  freeze PC.
- if_id_hold  out  1  freeze IF/ID register.
- id_ex_bubble  out  1  drives ID/EX `stall`; inserts a bubble.
- div_busy  out  1  divider occupied.
- div_done  out  1  one-cycle pulse: divider result valid, HI/LO write.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, cnt=0, div_done=0, stall_cycles=0.
  - div_busy=0, and all stall outputs 0.
  - Reset mid-divide abandons the divide; no div_done is produced.
- load_use (combinational): EX_MemRead & EX_RegWrite & (EX_wr_addr!=0) & ((EX_wr_addr==ID_rs) | (ID_uses_rt & (EX_wr_addr==ID_rt))).
  - Register $0 never causes a stall.
- div_hazard (combinational): div_busy & (ID_HiLo | ID_DivSel).
- stall = (load_use | div_hazard) & ~flush.
  - pc_hold = if_id_hold = id_ex_bubble = stall, all combinational, same cycle.
- Load-use: exactly one bubble.
  - After the bubble, the load leaves EX and forwarding covers the dependency.
- Divider FSM, negedge:
  - IDLE: if EX_DivSel, go to BUSY with cnt=DIV_CYCLES-1.
  - BUSY, cnt!=0: cnt decrements.
  - BUSY, cnt==0: go to IDLE and pulse div_done for exactly one cycle.
  - BUSY with EX_DivSel=1 (cannot occur in legal flow): reload cnt=DIV_CYCLES-1, no div_done for the abandoned divide.
- div_busy = (state==BUSY), registered output.
  - High for exactly DIV_CYCLES cycles, starting the cycle after the negedge where EX_DivSel is sampled.
- div_done is registered and never overlaps with div_busy=1 of the same divide.
  - A dependent mfhi/mflo stalls through the last busy cycle, then proceeds the cycle div_done is high.
  - The HI/LO write occurs at that negedge.
- flush does not abort a divide already in EX: FSM and counter continue unaffected.
- stall_cycles increments on every negedge where stall=1 and saturates at all-ones.
- Simultaneous load_use and div_hazard: single stall; counter +1 per cycle.

Test Plan:
- Load-use: lw $5 in EX (MemRead=1, RegWrite=1, EX_wr_addr=5) with ID_rs=5 -> stall outputs 1 for one cycle, stall_cycles 0->1; then the bubble leaves EX and stall returns to 0.
- Load to $0: EX_wr_addr=0, ID_rs=0 -> no stall. Same case with ID_uses_rt=0 and ID_rt=5 against EX_wr_addr=5 -> no stall.
- Divide: EX_DivSel pulse, with ID holding mflo (ID_HiLo=1):
  - div_busy high exactly 32 cycles;
  - stall high for those 32 cycles;
  - div_done pulses one cycle afterwards, with stall=0 in that cycle;
  - stall_cycles ends at 32 (plus any earlier counts).
- Flush during div_hazard -> stall outputs 0 that cycle; div_busy and cnt continue unchanged.
- Reset asserted at cnt=10 in BUSY -> div_busy, outputs and stall_cycles go 0 immediately, independent of the clock; no div_done after release.
- Saturation: force 65,540 stalled cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection between ID decode and the ID/EX register: load-use and
// divider/HI-LO hazards, divider occupancy tracking and a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 16
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic              ID_uses_rt,
  input  logic              ID_DivSel,
  input  logic              ID_HiLo,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [4:0]        EX_wr_addr,
  input  logic              EX_DivSel,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              id_ex_bubble,
  output logic              div_busy,
  output logic              div_done,
  output logic [PERF_W-1:0] stall_cycles,
  output logic              dbg_div_state
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV_CYCLES - 1);

  div_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              done_nxt;
  logic              load_use;
  logic              div_hazard;
  logic              stall;

  // $0 is hardwired zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = EX_MemRead & EX_RegWrite & (EX_wr_addr != 5'd0) &
               ((EX_wr_addr == ID_rs) | (ID_uses_rt & (EX_wr_addr == ID_rt)));
    div_hazard = div_busy & (ID_HiLo | ID_DivSel);
    stall = (load_use | div_hazard) & ~flush & ~reset;
  end

  assign pc_hold       = stall;
  assign if_id_hold    = stall;
  assign id_ex_bubble  = stall;
  assign div_busy      = (state == BUSY);
  assign dbg_div_state = state;

  // A new divide entering EX while busy restarts the count and drops the old result.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (EX_DivSel) begin
          state_nxt = BUSY;
          cnt_nxt   = RELOAD;
        end
      end
      BUSY: begin
        if (EX_DivSel) begin
          cnt_nxt = RELOAD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(negedge cpu_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div_done <= done_nxt;
    end
  end

  always_ff @(negedge cpu_clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
